gtp_tape_streamer: RTL



---
 rtl/gtp_tape_pkg.sv | 16 +
 rtl/gtp_byte_fifo.sv | 68 ++++++
 rtl/gtp_tape_streamer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gtp_tape_pkg.sv
// Shared types and default timing for the Galaksija tape playback stage.
package gtp_tape_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCell,
    StPause
  } tape_state_e;

  localparam int unsigned DefDepth       = 16;
  localparam int unsigned DefBitCycles   = 6250;
  localparam int unsigned DefPulseCycles = 625;
  localparam logic [7:0]  DefTapeIndex   = 8'd1;

endpackage

// File: rtl/gtp_byte_fifo.sv
// Byte FIFO with show-ahead read; flush wins over push/pop, push allowed when full if popping.
module gtp_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullLevel = (PW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FullLevel);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gtp_tape_streamer.sv
// Captures tape-image bytes from data_io into a FIFO and serialises them LSB first as
// pulse-coded bit cells: one pulse per cell, plus a mid-cell pulse for a 1 bit.
module gtp_tape_streamer
  import gtp_tape_pkg::*;
#(
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned BIT_CYCLES   = DefBitCycles,
  parameter int unsigned PULSE_CYCLES = DefPulseCycles,
  parameter logic [7:0]  TAPE_INDEX   = DefTapeIndex
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_dout,
  input  logic                     play,
  output logic                     clkref_n,
  output logic                     tape_out,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned TW = $clog2(BIT_CYCLES);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] TLast    = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TPulse   = TW'(PULSE_CYCLES);
  localparam logic [TW-1:0] THalf    = TW'(BIT_CYCLES / 2);
  localparam logic [TW-1:0] THalfEnd = TW'(BIT_CYCLES / 2 + PULSE_CYCLES);
  localparam logic [LW-1:0] SlackLvl = LW'(DEPTH - 2);

  tape_state_e   state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          dl_q;
  logic          tape_out_q, tape_out_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          clkref_n_q, clkref_n_d;

  logic          index_hit, rel_wr, flush, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] level;

  assign index_hit = (ioctl_index == TAPE_INDEX);
  assign rel_wr    = ioctl_wr & ioctl_download & index_hit;
  assign flush     = ioctl_download & ~dl_q & index_hit;
  assign pop       = (state_q == StLoad) & ~fifo_empty & ~flush;

  gtp_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (rel_wr),
    .pop     (pop),
    .flush   (flush),
    .wdata   (ioctl_dout),
    .rdata   (fifo_rdata),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (flush) begin
      state_d   = StIdle;
      t_d       = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: if (play && !fifo_empty) state_d = StLoad;
        StLoad: begin
          if (!fifo_empty) begin
            shift_d   = fifo_rdata;
            bit_cnt_d = '0;
            t_d       = '0;
            state_d   = StCell;
          end else begin
            state_d = StIdle;
          end
        end
        StCell: begin
          if (t_q != TLast) begin
            t_d = t_q + TW'(1);
          end else if (bit_cnt_q != 3'd7) begin
            // Pausing leaves the shifter untouched, so resuming replays the current bit.
            if (play) begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              t_d       = '0;
            end else begin
              state_d = StPause;
            end
          end else begin
            state_d = (play && !fifo_empty) ? StLoad : StIdle;
          end
        end
        StPause: begin
          if (play) begin
            t_d     = '0;
            state_d = StCell;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tape_out_d = (state_d == StCell) &&
                 ((t_d < TPulse) || (shift_d[0] && (t_d >= THalf) && (t_d < THalfEnd)));
    busy_d     = (state_d != StIdle);
    overflow_d = flush ? 1'b0 : (overflow_q | (rel_wr & fifo_full & ~pop));
    clkref_n_d = (level > SlackLvl);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      t_q        <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dl_q       <= 1'b0;
      tape_out_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      clkref_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dl_q       <= ioctl_download;
      tape_out_q <= tape_out_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      clkref_n_q <= clkref_n_d;
    end
  end

  assign tape_out   = tape_out_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign clkref_n   = clkref_n_q;
  assign fifo_level = level;

endmodule
